// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-2 DIT FFT sequencing logic.
// Holds the transform geometry, the controller state encoding, the word carried
// down the write-back delay line, and the butterfly address helper.
package fft_pkg;

  localparam int unsigned N_POINTS     = 16;
  localparam int unsigned LOG2N        = 4;
  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned TW_W         = 3;
  localparam int unsigned BF_PER_STAGE = N_POINTS / 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  // Read-side address triple for one butterfly.
  typedef struct packed {
    logic [ADDR_W-1:0] addr_1;
    logic [ADDR_W-1:0] addr_2;
    logic [TW_W-1:0]   twiddle;
  } bf_addr_t;

  // One delay-line slot: a butterfly issue tagged with its valid bit.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr_1;
    logic [ADDR_W-1:0] addr_2;
    logic [TW_W-1:0]   twiddle;
  } dl_word_t;

  // Operand addresses and twiddle index for butterfly k of the given stage.
  function automatic bf_addr_t bf_addr(input logic [1:0] stage, input logic [2:0] k);
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] grp;
    bf_addr_t          res;
    span        = ADDR_W'(1) << stage;
    pos         = {1'b0, k} & (span - ADDR_W'(1));
    grp         = {1'b0, k} >> stage;
    // grp * 2 * span, shifted in two steps so no intermediate overflows
    res.addr_1  = ((grp << 1) << stage) + pos;
    res.addr_2  = res.addr_1 + span;
    res.twiddle = TW_W'(pos << (2'd3 - stage));
    return res;
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with two taps.
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high clear of every stage
//   data_i      word entering the line this cycle
//   tap_first_o data_i delayed by one cycle
//   tap_last_o  data_i delayed by Depth cycles
module fft_delay_line #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] tap_first_o,
  output logic [Width-1:0] tap_last_o
);

  logic [Width-1:0] pipe_q [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= data_i;
      for (int i = 1; i < Depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tap_first_o = pipe_q[0];
  assign tap_last_o  = pipe_q[Depth-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Sequencing controller for the 16-point radix-2 DIT FFT.
// Issues one butterfly per cycle (8 per stage, 4 stages) to a ping-pong
// two-bank memory, then drains until every write of the stage has landed
// before swapping bank roles.
//   clk, rst       clock and synchronous active-high reset
//   start          one-cycle pulse to begin a transform (ignored while busy)
//   addr_1/addr_2  registered read addresses, top/bottom operand
//   addw_1/addw_2  write addresses, WR_DELAY cycles behind the reads
//   write_enable   write strobe, aligned with addw_*
//   select         1: read bank A / write bank B, 0: reverse
//   bf_valid       read data valid at the butterfly, with twiddle_idx
//   stage          current stage
//   busy, done     transform in progress / one-cycle completion pulse
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int unsigned BF_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addr_1,
  output logic [ADDR_W-1:0] addr_2,
  output logic [ADDR_W-1:0] addw_1,
  output logic [ADDR_W-1:0] addw_2,
  output logic              write_enable,
  output logic              select,
  output logic              bf_valid,
  output logic [TW_W-1:0]   twiddle_idx,
  output logic [1:0]        stage,
  output logic              busy,
  output logic              done
);

  // Memory read latency (1) plus butterfly pipeline depth.
  localparam int unsigned WR_DELAY  = 1 + BF_LATENCY;
  localparam logic [3:0]  DrainLast = 4'(WR_DELAY - 1);
  localparam logic [2:0]  LastBf    = 3'(BF_PER_STAGE - 1);

  state_e     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [2:0] k_q, k_d;
  logic [3:0] drain_q, drain_d;
  bf_addr_t   bf_q, bf_d;
  logic       select_q, select_d;
  logic       done_q, done_d;

  dl_word_t   dl_in, dl_tap1, dl_tapw;
  logic       unused_taps;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      drain_q  <= '0;
      bf_q     <= '0;
      select_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      k_q      <= k_d;
      drain_q  <= drain_d;
      bf_q     <= bf_d;
      select_q <= select_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    k_d      = k_q;
    drain_d  = drain_q;
    bf_d     = bf_q;
    select_d = select_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == LastBf) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DRAIN: begin
        if (drain_q == DrainLast) begin
          if (stage_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + 2'd1;
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Addresses are computed a cycle early so they are registered outputs
    // during the ISSUE cycle they belong to.
    if (state_d == ISSUE) begin
      bf_d = bf_addr(stage_d, k_d);
    end

    // Results of the last stage land in bank A, so leave it selected for reading.
    if (done_d) begin
      select_d = 1'b1;
    end else if (state_d != IDLE) begin
      select_d = ~stage_d[0];
    end
  end

  always_comb begin
    dl_in         = '0;
    dl_in.valid   = (state_q == ISSUE);
    dl_in.addr_1  = bf_q.addr_1;
    dl_in.addr_2  = bf_q.addr_2;
    dl_in.twiddle = bf_q.twiddle;
  end

  fft_delay_line #(
    .Width($bits(dl_word_t)),
    .Depth(WR_DELAY)
  ) u_delay_line (
    .clk_i      (clk),
    .rst_i      (rst),
    .data_i     (dl_in),
    .tap_first_o(dl_tap1),
    .tap_last_o (dl_tapw)
  );

  assign unused_taps = ^{dl_tap1.addr_1, dl_tap1.addr_2, dl_tapw.twiddle};

  assign addr_1       = bf_q.addr_1;
  assign addr_2       = bf_q.addr_2;
  assign bf_valid     = dl_tap1.valid;
  assign twiddle_idx  = dl_tap1.twiddle;
  assign addw_1       = dl_tapw.addr_1;
  assign addw_2       = dl_tapw.addr_2;
  assign write_enable = dl_tapw.valid;
  assign select       = select_q;
  assign stage        = stage_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen. Two instances run side by side:
// index 0 with BF_LATENCY=3, index 1 with BF_LATENCY=1.
module tb_fft_addr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start        [2];
  logic [3:0] addr_1       [2];
  logic [3:0] addr_2       [2];
  logic [3:0] addw_1       [2];
  logic [3:0] addw_2       [2];
  logic       write_enable [2];
  logic       select       [2];
  logic       bf_valid     [2];
  logic [2:0] twiddle_idx  [2];
  logic [1:0] stage        [2];
  logic       busy         [2];
  logic       done         [2];

  fft_addr_gen #(.BF_LATENCY(3)) dut_lat3 (
    .clk(clk), .rst(rst), .start(start[0]),
    .addr_1(addr_1[0]), .addr_2(addr_2[0]), .addw_1(addw_1[0]), .addw_2(addw_2[0]),
    .write_enable(write_enable[0]), .select(select[0]), .bf_valid(bf_valid[0]),
    .twiddle_idx(twiddle_idx[0]), .stage(stage[0]), .busy(busy[0]), .done(done[0])
  );

  fft_addr_gen #(.BF_LATENCY(1)) dut_lat1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .addr_1(addr_1[1]), .addr_2(addr_2[1]), .addw_1(addw_1[1]), .addw_2(addw_2[1]),
    .write_enable(write_enable[1]), .select(select[1]), .bf_valid(bf_valid[1]),
    .twiddle_idx(twiddle_idx[1]), .stage(stage[1]), .busy(busy[1]), .done(done[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rd_q [$];
  logic [2:0] tw_q [$];
  logic [7:0] wr_q [$];

  // Expected butterflies in issue order, enumerated group by group.
  task automatic push_expected();
    int span, a1;
    rd_q.delete();
    tw_q.delete();
    wr_q.delete();
    for (int s = 0; s < 4; s++) begin
      span = 1 << s;
      for (int g = 0; g < 8 / span; g++) begin
        for (int p = 0; p < span; p++) begin
          a1 = g * 2 * span + p;
          rd_q.push_back({4'(a1), 4'(a1 + span)});
          wr_q.push_back({4'(a1), 4'(a1 + span)});
          tw_q.push_back(3'(p * (8 / span)));
        end
      end
    end
  endtask

  task automatic pulse_start(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Called at the negedge of the first ISSUE cycle; checks every cycle through done.
  task automatic check_transform(input int d, input int mid_start, input bit chain);
    int         wr, per, we_cnt, s, j, cw;
    logic [7:0] exp_pair;
    logic [2:0] exp_tw;
    logic       exp_bfv, exp_we, exp_sel;
    logic [1:0] exp_stage;
    wr     = (d == 0) ? 4 : 2;
    per    = 8 + wr;
    we_cnt = 0;
    push_expected();
    for (int c = 0; c <= 4 * per; c++) begin
      if (c < 4 * per) begin
        s         = c / per;
        j         = c % per;
        exp_sel   = (s % 2 == 0);
        exp_stage = 2'(s);
        n_checks++;
        if (busy[d] !== 1'b1) $display("FAIL busy d=%0d c=%0d got=%0b exp=1", d, c, busy[d]);
        else n_pass++;
        n_checks++;
        if (stage[d] !== exp_stage)
          $display("FAIL stage d=%0d c=%0d got=%0d exp=%0d", d, c, stage[d], exp_stage);
        else n_pass++;
        n_checks++;
        if (select[d] !== exp_sel)
          $display("FAIL select d=%0d c=%0d got=%0b exp=%0b", d, c, select[d], exp_sel);
        else n_pass++;
        n_checks++;
        if (done[d] !== 1'b0) $display("FAIL early_done d=%0d c=%0d got=%0b exp=0", d, c, done[d]);
        else n_pass++;
        if (j < 8) begin
          exp_pair = rd_q.pop_front();
          n_checks++;
          if ({addr_1[d], addr_2[d]} !== exp_pair)
            $display("FAIL read_addr d=%0d c=%0d got=(%0d,%0d) exp=(%0d,%0d)", d, c,
                     addr_1[d], addr_2[d], exp_pair[7:4], exp_pair[3:0]);
          else n_pass++;
        end
      end else begin
        n_checks++;
        if (done[d] !== 1'b1) $display("FAIL done d=%0d c=%0d got=%0b exp=1", d, c, done[d]);
        else n_pass++;
        n_checks++;
        if (busy[d] !== 1'b0) $display("FAIL end_busy d=%0d c=%0d got=%0b exp=0", d, c, busy[d]);
        else n_pass++;
        n_checks++;
        if (select[d] !== 1'b1)
          $display("FAIL end_select d=%0d c=%0d got=%0b exp=1", d, c, select[d]);
        else n_pass++;
      end

      exp_bfv = (c >= 1) && (((c - 1) % per) < 8);
      n_checks++;
      if (bf_valid[d] !== exp_bfv)
        $display("FAIL bf_valid d=%0d c=%0d got=%0b exp=%0b", d, c, bf_valid[d], exp_bfv);
      else n_pass++;
      if (exp_bfv) begin
        exp_tw = tw_q.pop_front();
        n_checks++;
        if (twiddle_idx[d] !== exp_tw)
          $display("FAIL twiddle d=%0d c=%0d got=%0d exp=%0d", d, c, twiddle_idx[d], exp_tw);
        else n_pass++;
      end

      cw     = c - wr;
      exp_we = (cw >= 0) && ((cw % per) < 8);
      n_checks++;
      if (write_enable[d] !== exp_we)
        $display("FAIL write_enable d=%0d c=%0d got=%0b exp=%0b", d, c, write_enable[d], exp_we);
      else n_pass++;
      if (exp_we) begin
        exp_pair = wr_q.pop_front();
        we_cnt++;
        n_checks++;
        if ({addw_1[d], addw_2[d]} !== exp_pair)
          $display("FAIL write_addr d=%0d c=%0d got=(%0d,%0d) exp=(%0d,%0d)", d, c,
                   addw_1[d], addw_2[d], exp_pair[7:4], exp_pair[3:0]);
        else n_pass++;
      end

      start[d] = (c == mid_start) || (chain && c == 4 * per);
      @(negedge clk);
    end
    start[d] = 1'b0;

    n_checks++;
    if (we_cnt != 32) $display("FAIL we_count d=%0d got=%0d exp=32", d, we_cnt);
    else n_pass++;
    n_checks++;
    if (rd_q.size() + tw_q.size() + wr_q.size() != 0)
      $display("FAIL leftover d=%0d got=%0d exp=0", d, rd_q.size() + tw_q.size() + wr_q.size());
    else n_pass++;
    if (!chain) begin
      n_checks++;
      if (done[d] !== 1'b0) $display("FAIL done_width d=%0d got=%0b exp=0", d, done[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({addr_1[d], addr_2[d], addw_1[d], addw_2[d], write_enable[d], select[d],
           bf_valid[d], twiddle_idx[d], stage[d], busy[d], done[d]} !== 27'd0)
        $display("FAIL reset_outputs d=%0d got=%0h exp=0", d,
                 {addr_1[d], addr_2[d], addw_1[d], addw_2[d], write_enable[d], select[d],
                  bf_valid[d], twiddle_idx[d], stage[d], busy[d], done[d]});
      else n_pass++;
    end
    // start coincident with reset must be dropped
    start[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) $display("FAIL rst_wins got=%0b exp=0", busy[0]);
    else n_pass++;
    start[0] = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) $display("FAIL idle_after_rst got=%0b exp=0", busy[0]);
    else n_pass++;
  endtask

  task automatic test_full_run();
    pulse_start(0);
    check_transform(0, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    pulse_start(0);
    check_transform(0, 10, 1'b0);
  endtask

  task automatic test_latency1();
    pulse_start(1);
    check_transform(1, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    pulse_start(0);
    check_transform(0, -1, 1'b1);
    check_transform(0, -1, 1'b0);
  endtask

  task automatic test_reset_abort();
    int n_done, n_we, n_busy;
    pulse_start(0);
    repeat (28) @(negedge clk);  // stage 2, k = 4
    n_checks++;
    if ({stage[0], addr_1[0], addr_2[0]} !== {2'd2, 4'd8, 4'd12})
      $display("FAIL abort_point got=(%0d,%0d,%0d) exp=(2,8,12)", stage[0], addr_1[0], addr_2[0]);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy[0], write_enable[0], done[0]} !== 3'b000)
      $display("FAIL abort_state got=%03b exp=000", {busy[0], write_enable[0], done[0]});
    else n_pass++;
    n_done = 0;
    n_we   = 0;
    n_busy = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_done += int'(done[0]);
      n_we   += int'(write_enable[0]);
      n_busy += int'(busy[0]);
    end
    n_checks++;
    if (n_done + n_we + n_busy != 0)
      $display("FAIL abort_quiet got=%0d/%0d/%0d exp=0/0/0", n_done, n_we, n_busy);
    else n_pass++;
    pulse_start(0);
    check_transform(0, -1, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    test_reset();
    test_full_run();
    test_start_ignored();
    test_latency1();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
